// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the framed UART link (receiver and transmitter side).
// Holds the frame delimiter, checksum geometry, FSM state encodings and a
// small length-validation helper.
package uart_frame_rx_pkg;

    localparam logic [7:0] FRAME_INIT_BYTE = 8'hFE;
    localparam int         CSM_BYTES       = 4;
    localparam int         CSM_SIZE        = 32;

    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_OPT   = 3'd1,
        ST_LEN   = 3'd2,
        ST_DATA  = 3'd3,
        ST_CRC   = 3'd4,
        ST_CHECK = 3'd5
    } frame_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } byte_rx_state_e;

    // A length byte is usable only if it names at least one byte and fits the payload slot.
    function automatic logic frame_len_ok(input logic [7:0] len, input int max_bytes);
        return (len != 8'd0) && (int'(len) <= max_bytes);
    endfunction

endpackage

// File: rtl/crc_32.sv
// Bit-serial CRC-32 (reflected polynomial 0xEDB88320, init all-ones, final inversion).
// Ports: clk_i/rst_i clock and sync reset; init_i restarts the accumulator;
// in_valid_i/in_bit_i feed one bit (LSB-first wire order); in_last_i marks the final
// bit; out_valid_o pulses one cycle later with the finished checksum on crc_o.
module crc_32 #(
    parameter int CRC_SIZE = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                init_i,
    input  logic                in_valid_i,
    input  logic                in_bit_i,
    input  logic                in_last_i,
    output logic                out_valid_o,
    output logic [CRC_SIZE-1:0] crc_o
);

    localparam logic [CRC_SIZE-1:0] POLY = CRC_SIZE'(32'hEDB88320);

    logic [CRC_SIZE-1:0] crc_q, crc_d, nxt_s;
    logic [CRC_SIZE-1:0] crc_out_q, crc_out_d;
    logic                out_valid_q, out_valid_d;

    // Next accumulator value; the accumulator re-arms itself after the last bit.
    always_comb begin
        crc_d       = crc_q;
        crc_out_d   = crc_out_q;
        out_valid_d = 1'b0;
        nxt_s       = {1'b0, crc_q[CRC_SIZE-1:1]} ^ ((crc_q[0] ^ in_bit_i) ? POLY : '0);
        if (init_i) begin
            crc_d = '1;
        end else if (in_valid_i) begin
            if (in_last_i) begin
                crc_out_d   = ~nxt_s;
                out_valid_d = 1'b1;
                crc_d       = '1;
            end else begin
                crc_d = nxt_s;
            end
        end else begin
            crc_d = crc_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q       <= '1;
            crc_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            crc_q       <= crc_d;
            crc_out_q   <= crc_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign crc_o       = crc_out_q;

endmodule

// File: rtl/uart_frame_rx_byte.sv
// 8N1 byte deserialiser. Detects a falling edge on the idle line, confirms the
// start bit at mid-bit, samples BYTE_SIZE data bits LSB first and checks the stop bit.
// Ports: clk_i/rst_i clock and sync reset; in_bit_i serial line;
// bit_valid_o/bit_o/bit_last_o per data bit; byte_valid_o/byte_o on a good stop bit;
// stop_err_o when the stop bit reads 0. All outputs are registered 1-cycle pulses.
module uart_byte_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int BYTE_SIZE    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_bit_i,
    output logic                 bit_valid_o,
    output logic                 bit_o,
    output logic                 bit_last_o,
    output logic                 byte_valid_o,
    output logic [BYTE_SIZE-1:0] byte_o,
    output logic                 stop_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(BYTE_SIZE);

    byte_rx_state_e       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BYTE_SIZE-1:0] shreg_q, shreg_d;
    logic                 prev_q;
    logic                 bit_valid_q, bit_valid_d;
    logic                 bit_q, bit_d;
    logic                 bit_last_q, bit_last_d;
    logic                 byte_valid_q, byte_valid_d;
    logic                 stop_err_q, stop_err_d;

    // Bit-timing FSM: counter runs from the edge, samples land at mid-bit.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        bit_d        = bit_q;
        bit_valid_d  = 1'b0;
        bit_last_d   = 1'b0;
        byte_valid_d = 1'b0;
        stop_err_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !in_bit_i) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A start that has returned high by mid-bit was a glitch.
                    state_d = in_bit_i ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d       = '0;
                    shreg_d     = {in_bit_i, shreg_q[BYTE_SIZE-1:1]};
                    bit_d       = in_bit_i;
                    bit_valid_d = 1'b1;
                    if (idx_q == IDX_W'(BYTE_SIZE - 1)) begin
                        bit_last_d = 1'b1;
                        state_d    = RX_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (in_bit_i) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        stop_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // Timing state and registered pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shreg_q      <= '0;
            prev_q       <= 1'b1;
            bit_q        <= 1'b0;
            bit_valid_q  <= 1'b0;
            bit_last_q   <= 1'b0;
            byte_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            prev_q       <= in_bit_i;
            bit_q        <= bit_d;
            bit_valid_q  <= bit_valid_d;
            bit_last_q   <= bit_last_d;
            byte_valid_q <= byte_valid_d;
            stop_err_q   <= stop_err_d;
        end
    end

    assign bit_valid_o  = bit_valid_q;
    assign bit_o        = bit_q;
    assign bit_last_o   = bit_last_q;
    assign byte_valid_o = byte_valid_q;
    assign byte_o       = shreg_q;
    assign stop_err_o   = stop_err_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Framed UART receiver: FE | opt | len | data[len] | crc[4], CRC-32 over opt..data.
// Ports: CLK/RST clock and sync active-high reset; in_bit serial line (idle high);
// full_data/out_valid/out_ready output handshake carrying {opt,len,data} with the
// first data byte highest; crc_err, frm_err, overrun are 1-cycle error pulses.
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int FULL_DATA_SIZE = 40,
    parameter int BYTE_SIZE      = 8,
    parameter int CLKS_PER_BIT   = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_bit,
    output logic [FULL_DATA_SIZE-1:0] full_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      crc_err,
    output logic                      frm_err,
    output logic                      overrun
);

    localparam int DATA_BYTES = FULL_DATA_SIZE / BYTE_SIZE - 2;
    localparam int DATA_W     = FULL_DATA_SIZE - 2 * BYTE_SIZE;

    logic                 bit_valid_s, bit_s, bit_last_s, byte_valid_s, stop_err_s;
    logic [BYTE_SIZE-1:0] byte_s;
    logic                 crc_in_valid_s, crc_in_last_s, crc_init_s, crc_valid_s;
    logic [CSM_SIZE-1:0]  crc_out_s;
    logic                 commit_s, hshake_s;
    logic [DATA_W-1:0]    ins_s;
    int                   shift_s;

    frame_state_e              state_q, state_d;
    logic [BYTE_SIZE-1:0]      opt_q, opt_d, len_q, len_d, cnt_q, cnt_d;
    logic [DATA_W-1:0]         data_q, data_d;
    logic [CSM_SIZE-1:0]       rx_crc_q, rx_crc_d, crc_res_q, crc_res_d;
    logic                      crc_done_q, crc_done_d;
    logic [FULL_DATA_SIZE-1:0] full_q, full_d;
    logic                      out_valid_q, out_valid_d;
    logic                      crc_err_q, crc_err_d, frm_err_q, frm_err_d, overrun_q, overrun_d;

    uart_byte_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .BYTE_SIZE    (BYTE_SIZE)
    ) u_byte_rx (
        .clk_i        (CLK),
        .rst_i        (RST),
        .in_bit_i     (in_bit),
        .bit_valid_o  (bit_valid_s),
        .bit_o        (bit_s),
        .bit_last_o   (bit_last_s),
        .byte_valid_o (byte_valid_s),
        .byte_o       (byte_s),
        .stop_err_o   (stop_err_s)
    );

    // The checksum sees opt..data bits as they arrive; it is held re-armed while hunting.
    assign crc_init_s     = (state_q == ST_HUNT);
    assign crc_in_valid_s = bit_valid_s &&
                            ((state_q == ST_OPT) || (state_q == ST_LEN) || (state_q == ST_DATA));
    assign crc_in_last_s  = bit_last_s && (state_q == ST_DATA) &&
                            (cnt_q == len_q - BYTE_SIZE'(1));

    crc_32 #(
        .CRC_SIZE (CSM_SIZE)
    ) u_crc_32 (
        .clk_i       (CLK),
        .rst_i       (RST),
        .init_i      (crc_init_s),
        .in_valid_i  (crc_in_valid_s),
        .in_bit_i    (bit_s),
        .in_last_i   (crc_in_last_s),
        .out_valid_o (crc_valid_s),
        .crc_o       (crc_out_s)
    );

    // Data byte cnt lands cnt byte-slots below the top of the data field.
    assign shift_s  = int'(cnt_q) * BYTE_SIZE;
    assign ins_s    = {byte_s, {(DATA_W - BYTE_SIZE){1'b0}}} >> shift_s;
    assign hshake_s = out_valid_q && out_ready;

    // Frame parser, checksum compare and output-holding register.
    always_comb begin
        state_d     = state_q;
        opt_d       = opt_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        rx_crc_d    = rx_crc_q;
        crc_res_d   = crc_res_q;
        crc_done_d  = crc_done_q;
        full_d      = full_q;
        out_valid_d = out_valid_q;
        crc_err_d   = 1'b0;
        frm_err_d   = 1'b0;
        overrun_d   = 1'b0;
        commit_s    = 1'b0;

        if (state_q == ST_HUNT) begin
            crc_done_d = 1'b0;
        end else begin
            crc_done_d = crc_done_q;
        end
        // The checksum finishes during the last data byte, long before the CRC bytes end.
        if (crc_valid_s) begin
            crc_res_d  = crc_out_s;
            crc_done_d = 1'b1;
        end else begin
            crc_res_d = crc_res_q;
        end

        if (stop_err_s) begin
            frm_err_d = 1'b1;
            state_d   = ST_HUNT;
        end else if (byte_valid_s) begin
            case (state_q)
                ST_HUNT: begin
                    state_d = (byte_s == BYTE_SIZE'(FRAME_INIT_BYTE)) ? ST_OPT : ST_HUNT;
                end
                ST_OPT: begin
                    opt_d   = byte_s;
                    data_d  = '0;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    len_d = byte_s;
                    cnt_d = '0;
                    if (frame_len_ok(byte_s, DATA_BYTES)) begin
                        state_d = ST_DATA;
                    end else begin
                        frm_err_d = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end
                ST_DATA: begin
                    data_d = data_q | ins_s;
                    if (cnt_q == len_q - BYTE_SIZE'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_CRC;
                    end else begin
                        cnt_d = cnt_q + BYTE_SIZE'(1);
                    end
                end
                ST_CRC: begin
                    rx_crc_d = {rx_crc_q[CSM_SIZE-BYTE_SIZE-1:0], byte_s};
                    if (cnt_q == BYTE_SIZE'(CSM_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + BYTE_SIZE'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if ((state_q == ST_CHECK) && crc_done_q) begin
            state_d    = ST_HUNT;
            crc_done_d = 1'b0;
            if (rx_crc_q == crc_res_q) begin
                commit_s = 1'b1;
            end else begin
                crc_err_d = 1'b1;
            end
        end else begin
            commit_s = 1'b0;
        end

        // A consumer taking the held frame in the commit cycle frees the slot for the new one.
        if (commit_s) begin
            if (!out_valid_q || hshake_s) begin
                full_d      = {opt_q, len_q, data_q};
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (hshake_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Parser and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_HUNT;
            opt_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            rx_crc_q    <= '0;
            crc_res_q   <= '0;
            crc_done_q  <= 1'b0;
            full_q      <= '0;
            out_valid_q <= 1'b0;
            crc_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            opt_q       <= opt_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            rx_crc_q    <= rx_crc_d;
            crc_res_q   <= crc_res_d;
            crc_done_q  <= crc_done_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            crc_err_q   <= crc_err_d;
            frm_err_q   <= frm_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign full_data = full_q;
    assign out_valid = out_valid_q;
    assign crc_err   = crc_err_q;
    assign frm_err   = frm_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: serialises frames onto in_bit and checks the
// output register, handshake and error pulses against hand-computed values.
module tb_uart_frame_rx;

    localparam int CPB = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_bit;
    logic [39:0] full_data;
    logic        out_valid;
    logic        out_ready;
    logic        crc_err;
    logic        frm_err;
    logic        overrun;

    int vectors     = 0;
    int miscompares = 0;
    int n_crc = 0, n_frm = 0, n_ovr = 0;
    int b_crc = 0, b_frm = 0, b_ovr = 0;

    uart_frame_rx #(
        .FULL_DATA_SIZE (40),
        .BYTE_SIZE      (8),
        .CLKS_PER_BIT   (CPB)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_bit    (in_bit),
        .full_data (full_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .crc_err   (crc_err),
        .frm_err   (frm_err),
        .overrun   (overrun)
    );

    always #5 CLK = ~CLK;

    // Pulse counters, sampled on the inactive edge.
    always @(negedge CLK) begin
        if (crc_err === 1'b1) n_crc++;
        if (frm_err === 1'b1) n_frm++;
        if (overrun === 1'b1) n_ovr++;
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compares pulse counts since the previous call.
    task automatic check_pulses(input string tag, input int e_crc, input int e_frm, input int e_ovr);
        check({tag, ".crc_err"}, 40'(n_crc - b_crc), 40'(e_crc));
        check({tag, ".frm_err"}, 40'(n_frm - b_frm), 40'(e_frm));
        check({tag, ".overrun"}, 40'(n_ovr - b_ovr), 40'(e_ovr));
        b_crc = n_crc;
        b_frm = n_frm;
        b_ovr = n_ovr;
    endtask

    // Standard reflected CRC-32 over n bytes.
    function automatic logic [31:0] crc32_model(input logic [7:0] b[8], input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        in_bit = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            in_bit = b[i];
            repeat (CPB) @(negedge CLK);
        end
        in_bit = stop_ok;
        repeat (CPB) @(negedge CLK);
        in_bit = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    // Sends FE opt len data[len] crc[4]; stops after a byte sent with a bad stop bit.
    task automatic send_frame(input logic [7:0] opt, input logic [7:0] len, input logic [23:0] data,
                              input logic [31:0] crc_flip, input int bad_idx);
        logic [7:0]  fb[8];
        logic [7:0]  seq[12];
        logic [31:0] crc;
        int          n, total;
        for (int i = 0; i < 8; i++) fb[i] = 8'h00;
        fb[0] = opt;
        fb[1] = len;
        for (int k = 0; k < 3; k++) fb[2+k] = data[23-8*k -: 8];
        n   = 2 + ((len > 8'd3) ? 3 : int'(len));
        crc = crc32_model(fb, n) ^ crc_flip;
        seq[0] = 8'hFE;
        for (int i = 0; i < n; i++) seq[1+i] = fb[i];
        total = 1 + n;
        if (len != 8'd0) begin
            for (int k = 0; k < 4; k++) seq[total+k] = crc[31-8*k -: 8];
            total = total + 4;
        end
        for (int i = 0; i < total; i++) begin
            send_byte(seq[i], i != bad_idx);
            if (i == bad_idx) break;
        end
        repeat (10) @(negedge CLK);
    endtask

    task automatic take_output(input string tag);
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        check({tag, ".valid_clear"}, 40'(out_valid), 40'd0);
    endtask

    initial begin
        RST       = 1'b1;
        in_bit    = 1'b1;
        out_ready = 1'b0;
        repeat (4) @(negedge CLK);
        check("reset.full_data", full_data, 40'd0);
        check("reset.out_valid", 40'(out_valid), 40'd0);
        check("reset.crc_err", 40'(crc_err), 40'd0);
        check("reset.frm_err", 40'(frm_err), 40'd0);
        check("reset.overrun", 40'(overrun), 40'd0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        // 1: three-byte payload
        send_frame(8'h11, 8'd3, 24'hAABBCC, 32'h0, -1);
        check("t1.out_valid", 40'(out_valid), 40'd1);
        check("t1.full_data", full_data, 40'h1103AABBCC);
        check_pulses("t1", 0, 0, 0);
        take_output("t1");

        // 2: one-byte payload, low data bytes zero
        send_frame(8'h11, 8'd1, 24'h5A0000, 32'h0, -1);
        check("t2.out_valid", 40'(out_valid), 40'd1);
        check("t2.full_data", full_data, 40'h11015A0000);
        check_pulses("t2", 0, 0, 0);
        take_output("t2");

        // 3: corrupted final CRC byte
        send_frame(8'h11, 8'd3, 24'hAABBCC, 32'h0000_0001, -1);
        check("t3.out_valid", 40'(out_valid), 40'd0);
        check_pulses("t3", 1, 0, 0);

        // 4: bad stop bit in the second data byte, then a good frame
        send_frame(8'h11, 8'd3, 24'hAABBCC, 32'h0, 4);
        check("t4.out_valid", 40'(out_valid), 40'd0);
        check_pulses("t4", 0, 1, 0);
        send_frame(8'h22, 8'd2, 24'h123400, 32'h0, -1);
        check("t4b.out_valid", 40'(out_valid), 40'd1);
        check("t4b.full_data", full_data, 40'h2202123400);
        check_pulses("t4b", 0, 0, 0);
        take_output("t4b");

        // 5: second frame arrives while the first is held
        send_frame(8'h11, 8'd3, 24'hAABBCC, 32'h0, -1);
        check("t5a.out_valid", 40'(out_valid), 40'd1);
        send_frame(8'h33, 8'd1, 24'h770000, 32'h0, -1);
        check("t5b.out_valid", 40'(out_valid), 40'd1);
        check("t5b.full_data", full_data, 40'h1103AABBCC);
        check_pulses("t5", 0, 0, 1);
        take_output("t5");

        // 6: garbage before the delimiter is ignored, len=0 is a framing error
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_frame(8'h11, 8'd0, 24'h000000, 32'h0, -1);
        check("t6.out_valid", 40'(out_valid), 40'd0);
        check_pulses("t6", 0, 1, 0);

        // 6b: reset in the middle of the data field
        send_byte(8'hFE, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'hAA, 1'b1);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        check("t6r.out_valid", 40'(out_valid), 40'd0);
        check("t6r.full_data", full_data, 40'd0);
        check_pulses("t6r", 0, 0, 0);
        send_frame(8'h44, 8'd3, 24'h010203, 32'h0, -1);
        check("t6c.out_valid", 40'(out_valid), 40'd1);
        check("t6c.full_data", full_data, 40'h4403010203);
        check_pulses("t6c", 0, 0, 0);
        take_output("t6c");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
